pwm_fade_ctrl: RTL and testbench
================================

PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 The block SHALL have parameter DUTY_ADDR, default 7'h04, giving the register-bank address of the PWM duty-cycle register.
REQ-002 The block SHALL have these ports:
- clk  input  1  single system clock, all logic on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to begin a fade.
- abort  input  1  one-cycle request to stop the fade.
- target  input  8  final duty value, sampled on an accepted start.
- step_div  input  8  step prescaler, sampled on an accepted start.
- spi_wr_valid  input  1  SPI peripheral write strobe.
- spi_wr_addr  input  7  SPI write address.
- spi_wr_data  input  8  SPI write data.
- reg_wr_en  output  1  register-bank write strobe.
- reg_wr_addr  output  7  register-bank write address.
- reg_wr_data  output  8  register-bank write data.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse when the fade completes.

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, WAIT, WRITE, DONE.
REQ-004 The block SHALL keep an 8-bit duty shadow equal to the last value written to DUTY_ADDR by either source.
REQ-005 In IDLE, start=1 SHALL latch target and step_div and load the prescaler with step_div.
- If the shadow equals target, the next state SHALL be DONE.
- Otherwise the next state SHALL be WAIT.
REQ-006 start SHALL be ignored in every state other than IDLE.
REQ-007 In WAIT, the prescaler SHALL decrement by 1 each cycle.
- When it reads 0, the next state SHALL be WRITE.
- WAIT therefore lasts step_div+1 cycles.
REQ-008 In WRITE with spi_wr_valid=0, the ramp write SHALL be granted:
- next shadow = shadow+1 if shadow<target, else shadow-1;
- a write of the new value to DUTY_ADDR SHALL be issued;
- next state SHALL be DONE if the new value equals target, else WAIT with the prescaler reloaded to step_div.
REQ-009 In WRITE with spi_wr_valid=1, the SPI write SHALL win, and the block SHALL stay in WRITE with no ramp step taken.
REQ-010 SPI writes SHALL be forwarded in every state. The fixed priority is SPI over ramp; at most one write is issued per cycle.
REQ-011 An SPI write to DUTY_ADDR SHALL update the shadow to spi_wr_data.
- During WAIT or WRITE, the fade SHALL continue from the new value.
- If the new value equals the latched target, the next state SHALL be DONE.
REQ-012 reg_wr_en, reg_wr_addr and reg_wr_data SHALL be registered. A write decided in cycle N SHALL appear on them in cycle N+1, for exactly one cycle.
REQ-013 reg_wr_addr and reg_wr_data SHALL hold their last value while reg_wr_en=0.
REQ-014 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-015 abort=1 in WAIT or WRITE SHALL force IDLE on the next edge and issue no ramp write.
- A simultaneous SPI write SHALL still be forwarded.
- done SHALL stay 0.
REQ-016 The duty arithmetic SHALL be unsigned 8-bit. Stepping SHALL never wrap, because the step direction always moves toward target.
REQ-017 busy SHALL be combinational from state, and done SHALL be high only in DONE.

Reset
REQ-018 With rst_n=0 on a rising edge, the following SHALL hold on the next cycle, regardless of state or pending SPI write:
- state = IDLE, shadow = 0, prescaler = 0;
- latched target and step_div = 0;
- reg_wr_en = 0, reg_wr_addr = 0, reg_wr_data = 0;
- busy = 0, done = 0.
REQ-019 A reset asserted mid-fade SHALL discard the fade, and no write SHALL issue in the cycle after reset.

Verification
REQ-020 Reset, then start with target=3 and step_div=1 -> writes 1, 2, 3 to 0x04 spaced 3 cycles apart, first write visible 4 cycles after start, done pulses once, busy falls after done.
REQ-021 SPI writes 0x0A to 0x04, then start with target=0x08 and step_div=0 -> writes 0x09 then 0x08, done pulses once.
REQ-022 Start with target=5 and step_div=0, and hold spi_wr_valid=1 to addr 0x00 for 3 cycles while in WRITE -> 3 SPI writes pass through first, the ramp write of 1 follows, and no cycle carries two writes.
REQ-023 Start with target=0x10; after the write of 0x02, SPI writes 0x10 to 0x04 -> no further ramp writes, done pulses on the next cycle.
REQ-024 Abort during WAIT, and separately assert rst_n=0 during WAIT -> no ramp write, done stays 0, IDLE next cycle; a following start with shadow equal to target gives done with zero writes.

Source files
------------

// File: rtl/pwm_fade_ctrl.sv
// Fades a PWM duty register one LSB at a time toward a target value, while
// forwarding SPI register writes with priority over the ramp's own writes.
module pwm_fade_ctrl #(
    parameter logic [6:0] DUTY_ADDR = 7'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] target,
    input  logic [7:0] step_div,
    input  logic       spi_wr_valid,
    input  logic [6:0] spi_wr_addr,
    input  logic [7:0] spi_wr_data,
    output logic       reg_wr_en,
    output logic [6:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, WAIT, WRITE, DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] presc_q, presc_d;
    logic [7:0] tgt_q, tgt_d;
    logic [7:0] div_q, div_d;
    logic       wr_en_d;
    logic [6:0] wr_addr_d;
    logic [7:0] wr_data_d;
    logic       spi_hit;
    logic [7:0] ramp_val;

    assign spi_hit  = spi_wr_valid && (spi_wr_addr == DUTY_ADDR);
    // Direction always points at the target, so this never wraps.
    assign ramp_val = (shadow_q < tgt_q) ? shadow_q + 8'd1 : shadow_q - 8'd1;

    always_comb begin
        state_d   = state_q;
        shadow_d  = spi_hit ? spi_wr_data : shadow_q;
        presc_d   = presc_q;
        tgt_d     = tgt_q;
        div_d     = div_q;
        wr_en_d   = spi_wr_valid;
        wr_addr_d = spi_wr_valid ? spi_wr_addr : reg_wr_addr;
        wr_data_d = spi_wr_valid ? spi_wr_data : reg_wr_data;
        case (state_q)
            IDLE: begin
                if (start) begin
                    tgt_d   = target;
                    div_d   = step_div;
                    presc_d = step_div;
                    state_d = (shadow_q == target) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (spi_hit && (spi_wr_data == tgt_q)) begin
                    state_d = DONE;
                end else if (presc_q == 8'd0) begin
                    state_d = WRITE;
                end else begin
                    presc_d = presc_q - 8'd1;
                end
            end
            WRITE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (spi_wr_valid) begin
                    // SPI owns the bus this cycle; the ramp step waits.
                    if (spi_hit && (spi_wr_data == tgt_q)) begin
                        state_d = DONE;
                    end
                end else begin
                    shadow_d  = ramp_val;
                    wr_en_d   = 1'b1;
                    wr_addr_d = DUTY_ADDR;
                    wr_data_d = ramp_val;
                    if (ramp_val == tgt_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                        presc_d = div_q;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shadow_q    <= 8'd0;
            presc_q     <= 8'd0;
            tgt_q       <= 8'd0;
            div_q       <= 8'd0;
            reg_wr_en   <= 1'b0;
            reg_wr_addr <= 7'd0;
            reg_wr_data <= 8'd0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            presc_q     <= presc_d;
            tgt_q       <= tgt_d;
            div_q       <= div_d;
            reg_wr_en   <= wr_en_d;
            reg_wr_addr <= wr_addr_d;
            reg_wr_data <= wr_data_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl: a fade-progress model is compared against
// the DUT every cycle, and each scenario pins its write log with literals.
module tb_pwm_fade_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] target = 8'd0;
    logic [7:0] step_div = 8'd0;
    logic       spi_wr_valid = 1'b0;
    logic [6:0] spi_wr_addr = 7'd0;
    logic [7:0] spi_wr_data = 8'd0;
    logic       reg_wr_en;
    logic [6:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic       busy;
    logic       done;

    pwm_fade_ctrl #(.DUTY_ADDR(7'h04)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .target(target), .step_div(step_div),
        .spi_wr_valid(spi_wr_valid), .spi_wr_addr(spi_wr_addr), .spi_wr_data(spi_wr_data),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .busy(busy), .done(done)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // model: fade described as "cycles elapsed since the last step"
    int m_duty = 0, m_tgt = 0, m_div = 0, m_elapsed = 0;
    int m_addr = 0, m_data = 0;
    bit m_fade = 0, m_done = 0, m_en = 0;

    // write log seen on the register-bank port
    int wl_data[$];
    int wl_addr[$];
    int wl_cyc[$];
    int done_cnt = 0;
    int last_done_cyc = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        bit hit, was_done;
        cyc++;
        if (!rst_n) begin
            m_duty = 0; m_tgt = 0; m_div = 0; m_elapsed = 0;
            m_addr = 0; m_data = 0; m_fade = 0; m_done = 0; m_en = 0;
        end else begin
            hit = spi_wr_valid && (spi_wr_addr == 7'h04);
            was_done = m_done;
            m_done = 0;
            m_en = 0;
            if (spi_wr_valid) begin
                m_en = 1; m_addr = int'(spi_wr_addr); m_data = int'(spi_wr_data);
            end
            if (m_fade) begin
                if (abort) begin
                    m_fade = 0;
                end else if (hit) begin
                    m_duty = int'(spi_wr_data);
                    if (m_duty == m_tgt) begin
                        m_fade = 0; m_done = 1;
                    end else begin
                        m_elapsed++;
                    end
                end else if (m_elapsed > m_div && !spi_wr_valid) begin
                    m_duty = (m_duty < m_tgt) ? m_duty + 1 : m_duty - 1;
                    m_en = 1; m_addr = 4; m_data = m_duty;
                    if (m_duty == m_tgt) begin
                        m_fade = 0; m_done = 1;
                    end else begin
                        m_elapsed = 0;
                    end
                end else begin
                    m_elapsed++;
                end
            end else if (was_done) begin
                if (hit) m_duty = int'(spi_wr_data);
            end else begin
                if (start) begin
                    m_tgt = int'(target); m_div = int'(step_div);
                    if (m_duty == int'(target)) m_done = 1;
                    else begin m_fade = 1; m_elapsed = 0; end
                end
                if (hit) m_duty = int'(spi_wr_data);
            end
        end
    end

    // scoreboard: every cycle after the first edge
    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("reg_wr_en", {31'd0, reg_wr_en}, {31'd0, m_en});
            chk("reg_wr_addr", {25'd0, reg_wr_addr}, m_addr);
            chk("reg_wr_data", {24'd0, reg_wr_data}, m_data);
            chk("busy", {31'd0, busy}, {31'd0, (m_fade | m_done)});
            chk("done", {31'd0, done}, {31'd0, m_done});
            if (reg_wr_en === 1'b1) begin
                wl_data.push_back(int'(reg_wr_data));
                wl_addr.push_back(int'(reg_wr_addr));
                wl_cyc.push_back(cyc);
            end
            if (done === 1'b1) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #2;
        start = 1'b0; abort = 1'b0; spi_wr_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic spi(input logic [6:0] a, input logic [7:0] d);
        spi_wr_valid = 1'b1; spi_wr_addr = a; spi_wr_data = d;
        tick();
    endtask

    task automatic go(input logic [7:0] t, input logic [7:0] dv);
        start = 1'b1; target = t; step_div = dv;
        tick();
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            rst_n = 1'b0;
            spi_wr_valid = 1'b1; spi_wr_addr = 7'h04; spi_wr_data = 8'h77;
            tick();
        end
        rst_n = 1'b1;
        chk("rst_wr_en", {31'd0, reg_wr_en}, 32'd0);
        chk("rst_wr_addr", {25'd0, reg_wr_addr}, 32'd0);
        chk("rst_wr_data", {24'd0, reg_wr_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
    endtask

    task automatic clear_log();
        wl_data.delete(); wl_addr.delete(); wl_cyc.delete();
        done_cnt = 0; last_done_cyc = -1;
    endtask

    initial begin
        int t0;
        do_reset(2);

        // ramp 0 -> 3, prescaler 1: writes every 3 cycles, first at +4
        clear_log();
        t0 = cyc;
        go(8'd3, 8'd1);
        idle(14);
        chk("s1_nwr", wl_data.size(), 3);
        if (wl_data.size() == 3) begin
            chk("s1_d0", wl_data[0], 1); chk("s1_d1", wl_data[1], 2); chk("s1_d2", wl_data[2], 3);
            chk("s1_a0", wl_addr[0], 4);
            chk("s1_c0", wl_cyc[0], t0 + 4); chk("s1_c1", wl_cyc[1], t0 + 7); chk("s1_c2", wl_cyc[2], t0 + 10);
        end
        chk("s1_done_cnt", done_cnt, 1);
        chk("s1_done_cyc", last_done_cyc, t0 + 10);

        // SPI sets duty to 0x0A, then ramp down to 0x08
        clear_log();
        spi(7'h04, 8'h0A);
        t0 = cyc;
        go(8'h08, 8'd0);
        idle(8);
        chk("s2_nwr", wl_data.size(), 3);
        if (wl_data.size() == 3) begin
            chk("s2_d0", wl_data[0], 'h0A); chk("s2_d1", wl_data[1], 'h09); chk("s2_d2", wl_data[2], 'h08);
            chk("s2_c1", wl_cyc[1], t0 + 3); chk("s2_c2", wl_cyc[2], t0 + 5);
        end
        chk("s2_done_cnt", done_cnt, 1);

        // SPI traffic to another register stalls the ramp while in WRITE
        do_reset(1);
        clear_log();
        t0 = cyc;
        go(8'd5, 8'd0);
        idle(1);
        spi(7'h00, 8'h55); spi(7'h00, 8'h66); spi(7'h00, 8'h77);
        idle(14);
        chk("s3_nwr", wl_data.size(), 8);
        if (wl_data.size() == 8) begin
            chk("s3_d0", wl_data[0], 'h55); chk("s3_d2", wl_data[2], 'h77);
            chk("s3_a2", wl_addr[2], 0);
            chk("s3_d3", wl_data[3], 1); chk("s3_a3", wl_addr[3], 4);
            chk("s3_c0", wl_cyc[0], t0 + 3); chk("s3_c3", wl_cyc[3], t0 + 6);
            chk("s3_d7", wl_data[7], 5); chk("s3_c7", wl_cyc[7], t0 + 14);
        end
        chk("s3_done_cnt", done_cnt, 1);

        // SPI lands on the target mid-fade: finishes at once
        do_reset(1);
        clear_log();
        t0 = cyc;
        go(8'h10, 8'd1);
        idle(6);
        spi(7'h04, 8'h10);
        idle(8);
        chk("s4_nwr", wl_data.size(), 3);
        if (wl_data.size() == 3) begin
            chk("s4_d1", wl_data[1], 2); chk("s4_d2", wl_data[2], 'h10);
            chk("s4_c2", wl_cyc[2], t0 + 8);
        end
        chk("s4_done_cnt", done_cnt, 1);
        chk("s4_done_cyc", last_done_cyc, t0 + 8);

        // abort in WAIT with a concurrent SPI write elsewhere
        do_reset(1);
        clear_log();
        go(8'd3, 8'd3);
        idle(1);
        abort = 1'b1;
        spi(7'h11, 8'h22);
        chk("s5_busy_after_abort", {31'd0, busy}, 32'd0);
        idle(4);
        chk("s5_nwr", wl_data.size(), 1);
        if (wl_data.size() == 1) begin
            chk("s5_d0", wl_data[0], 'h22); chk("s5_a0", wl_addr[0], 'h11);
        end
        chk("s5_done_cnt", done_cnt, 0);
        clear_log();
        go(8'd0, 8'd2);
        chk("s5_done_now", {31'd0, done}, 32'd1);
        idle(3);
        chk("s5_zero_nwr", wl_data.size(), 0);
        chk("s5_zero_done", done_cnt, 1);

        // reset in WAIT discards the fade
        clear_log();
        go(8'd3, 8'd3);
        idle(1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("s6_busy", {31'd0, busy}, 32'd0);
        chk("s6_wr_en", {31'd0, reg_wr_en}, 32'd0);
        idle(4);
        chk("s6_nwr", wl_data.size(), 0);
        chk("s6_done_cnt", done_cnt, 0);
        go(8'd0, 8'd0);
        idle(3);
        chk("s6_zero_nwr", wl_data.size(), 0);
        chk("s6_zero_done", done_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
